// File: rtl/multicycle_memory.sv
// Unified instruction/data memory for the multicycle CPU. Accepts one read or write
// request at a time and answers with a single-cycle mem_ready pulse after LATENCY edges.
module multicycle_memory #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  mem_ready,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  isWrite_q, isWrite_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  commit;

  // The counter starts at LATENCY so that DONE is always entered LATENCY edges after acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    isWrite_d = isWrite_q;
    dout_d    = dout_q;
    ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d     = addr[2 +: IDX_W];
          wdata_d   = din;
          isWrite_d = mem_write;
          cnt_d     = LAT_INIT;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          cnt_d   = '0;
          ready_d = 1'b1;
          if (!isWrite_q) begin
            dout_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      isWrite_q <= 1'b0;
      dout_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      isWrite_q <= isWrite_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Array is left unreset so it can map onto block RAM; reset still cancels an in-flight write.
  assign commit = (state_q == S_WAIT) && (cnt_q == CNT_ONE) && isWrite_q && !reset;

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  generate
    if (ADDR_WIDTH > IDX_W + 2) begin : g_upper
      logic unusedAddrBits;
      assign unusedAddrBits = ^{addr[1:0], addr[ADDR_WIDTH-1:IDX_W+2]};
    end else begin : g_noUpper
      logic unusedAddrBits;
      assign unusedAddrBits = ^addr[1:0];
    end
  endgenerate

  assign dout      = dout_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multicycle_memory.sv
// Self-checking bench for multicycle_memory: directed scenarios plus randomized traffic
// against a word-array reference model, on a LATENCY=2 and a LATENCY=1 instance.
module tb_multicycle_memory;

  localparam int DEPTH0 = 16384;
  localparam int LAT0   = 2;
  localparam int DEPTH1 = 16;
  localparam int LAT1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] addr0, din0, dout0, addr1, din1, dout1;
  logic        rd0, wr0, ready0, busy0, rd1, wr1, ready1, busy1;

  int nVec = 0;
  int nErr = 0;
  int activeDut = 0;

  logic [31:0] model0 [int];
  logic [31:0] model1 [int];
  logic [31:0] lastRead [2];

  multicycle_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH0), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset), .addr(addr0), .din(din0), .mem_read(rd0), .mem_write(wr0),
    .dout(dout0), .mem_ready(ready0), .busy(busy0)
  );

  multicycle_memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH1), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr1), .din(din1), .mem_read(rd1), .mem_write(wr1),
    .dout(dout1), .mem_ready(ready1), .busy(busy1)
  );

  function automatic logic curReady();
    return (activeDut == 0) ? ready0 : ready1;
  endfunction

  function automatic logic curBusy();
    return (activeDut == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [31:0] curDout();
    return (activeDut == 0) ? dout0 : dout1;
  endfunction

  function automatic int expLat();
    return (activeDut == 0) ? LAT0 + 1 : LAT1 + 1;
  endfunction

  task automatic setInputs(input logic [31:0] a, input logic [31:0] d, input bit isRd, input bit isWr);
    if (activeDut == 0) begin
      addr0 = a; din0 = d; rd0 = isRd; wr0 = isWr;
    end else begin
      addr1 = a; din1 = d; rd1 = isRd; wr1 = isWr;
    end
  endtask

  // Reference: memory is a plain word array indexed by (addr/4) mod DEPTH; writes leave dout alone.
  task automatic modelAccess(input bit isWr, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] expData);
    int k;
    k = (activeDut == 0) ? int'((a >> 2) % DEPTH0) : int'((a >> 2) % DEPTH1);
    if (isWr) begin
      if (activeDut == 0) model0[k] = d;
      else                model1[k] = d;
      expData = lastRead[activeDut];
    end else begin
      expData = (activeDut == 0) ? model0[k] : model1[k];
      lastRead[activeDut] = expData;
    end
  endtask

  task automatic doAccess(input bit isRd, input bit isWr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rdata, output bit busyOk);
    @(negedge clk);
    setInputs(a, d, isRd, isWr);
    @(posedge clk);
    lat = 0;
    busyOk = 1'b1;
    rdata = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      setInputs(a, d, 1'b0, 1'b0);
      if (!curBusy()) busyOk = 1'b0;
      if (curReady()) begin
        rdata = curDout();
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    activeDut = 0; setInputs('0, '0, 1'b0, 1'b0);
    activeDut = 1; setInputs('0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      nVec++;
      if ({ready0, busy0, dout0} !== 34'd0) begin
        nErr++;
        $display("[TB] FAIL reset_dut0 cyc%0d: ready=%0b busy=%0b dout=%08h, required all zero", c, ready0, busy0, dout0);
      end
      nVec++;
      if ({ready1, busy1, dout1} !== 34'd0) begin
        nErr++;
        $display("[TB] FAIL reset_dut1 cyc%0d: ready=%0b busy=%0b dout=%08h, required all zero", c, ready1, busy1, dout1);
      end
    end
    lastRead[0] = '0;
    lastRead[1] = '0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd, exp; bit bok;
    activeDut = 0;
    modelAccess(1'b1, 32'h10, 32'hDEADBEEF, exp);
    doAccess(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, bok);
    nVec++;
    if (lat !== expLat() || !bok) begin
      nErr++;
      $display("[TB] FAIL wr_latency: got %0d (busyOk=%0b), required %0d with busy", lat, bok, expLat());
    end
    modelAccess(1'b0, 32'h10, '0, exp);
    doAccess(1'b1, 1'b0, 32'h10, '0, lat, rd, bok);
    nVec++;
    if (lat !== expLat() || rd !== exp || !bok) begin
      nErr++;
      $display("[TB] FAIL rd_deadbeef: lat=%0d data=%08h, required lat=%0d data=%08h", lat, rd, expLat(), exp);
    end
    repeat (2) begin
      @(negedge clk);
      nVec++;
      if (dout0 !== exp || ready0 !== 1'b0 || busy0 !== 1'b0) begin
        nErr++;
        $display("[TB] FAIL rd_hold: dout=%08h ready=%0b busy=%0b, required %08h 0 0", dout0, ready0, busy0, exp);
      end
    end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd, exp; bit bok;
    logic [31:0] aliasAddrs [2];
    activeDut = 0;
    aliasAddrs[0] = 32'h10;
    aliasAddrs[1] = 32'h10 + 32'(4 * DEPTH0);
    modelAccess(1'b1, 32'h13, 32'h12345678, exp);
    doAccess(1'b0, 1'b1, 32'h13, 32'h12345678, lat, rd, bok);
    for (int i = 0; i < 2; i++) begin
      modelAccess(1'b0, aliasAddrs[i], '0, exp);
      doAccess(1'b1, 1'b0, aliasAddrs[i], '0, lat, rd, bok);
      nVec++;
      if (rd !== exp || lat !== expLat()) begin
        nErr++;
        $display("[TB] FAIL alias_%08h: data=%08h lat=%0d, required %08h lat=%0d", aliasAddrs[i], rd, lat, exp, expLat());
      end
    end
  endtask

  task automatic test_ignore_in_wait();
    int lat; logic [31:0] rd, exp, got; bit bok;
    int pulses;
    activeDut = 0;
    modelAccess(1'b1, 32'h20, 32'hCAFEF00D, exp);
    doAccess(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, lat, rd, bok);
    modelAccess(1'b0, 32'h10, '0, exp);
    @(negedge clk);
    setInputs(32'h10, '0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    setInputs(32'h20, 32'hBAD0BAD0, 1'b0, 1'b1);
    pulses = 0;
    got = '0;
    for (int c = 0; c < 10; c++) begin
      if (ready0) begin
        pulses++;
        got = dout0;
        setInputs(32'h20, 32'hBAD0BAD0, 1'b0, 1'b0);
      end
      @(negedge clk);
    end
    setInputs('0, '0, 1'b0, 1'b0);
    nVec++;
    if (pulses !== 1) begin
      nErr++;
      $display("[TB] FAIL wait_pulses: got %0d pulses, required 1", pulses);
    end
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("[TB] FAIL wait_data: got %08h, required %08h", got, exp);
    end
    modelAccess(1'b0, 32'h20, '0, exp);
    doAccess(1'b1, 1'b0, 32'h20, '0, lat, rd, bok);
    nVec++;
    if (rd !== exp) begin
      nErr++;
      $display("[TB] FAIL wait_no_write: addr 0x20 holds %08h, required %08h", rd, exp);
    end
  endtask

  task automatic test_both_strobes();
    int lat; logic [31:0] rd, exp; bit bok;
    activeDut = 0;
    modelAccess(1'b1, 32'h8, 32'hA5A5A5A5, exp);
    doAccess(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, lat, rd, bok);
    nVec++;
    if (rd !== exp || lat !== expLat()) begin
      nErr++;
      $display("[TB] FAIL both_dout: dout=%08h lat=%0d, required unchanged %08h lat=%0d", rd, lat, exp, expLat());
    end
    modelAccess(1'b0, 32'h8, '0, exp);
    doAccess(1'b1, 1'b0, 32'h8, '0, lat, rd, bok);
    nVec++;
    if (rd !== exp) begin
      nErr++;
      $display("[TB] FAIL both_readback: got %08h, required %08h", rd, exp);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, exp, a, d; bit bok;
    int op;
    activeDut = 0;
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      modelAccess(1'b1, 32'(k * 4), d, exp);
      doAccess(1'b0, 1'b1, 32'(k * 4), d, lat, rd, bok);
    end
    for (int n = 0; n < 30; n++) begin
      a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 255)) << 16);
      d = $urandom;
      op = $urandom_range(0, 2);
      modelAccess(op != 0, a, d, exp);
      doAccess(op != 1, op != 0, a, d, lat, rd, bok);
      nVec++;
      if (rd !== exp || lat !== expLat() || !bok) begin
        nErr++;
        $display("[TB] FAIL rand%0d op%0d a=%08h: data=%08h lat=%0d busyOk=%0b, required %08h lat=%0d", n, op, a, rd, lat, bok, exp, expLat());
      end
    end
  endtask

  task automatic test_reset_abort(input int sel);
    int lat; logic [31:0] rd, exp; bit bok;
    int pulses;
    activeDut = sel;
    modelAccess(1'b1, 32'h4, 32'h22222222, exp);
    doAccess(1'b0, 1'b1, 32'h4, 32'h22222222, lat, rd, bok);
    nVec++;
    if (lat !== expLat() || !bok) begin
      nErr++;
      $display("[TB] FAIL abort_pre_lat dut%0d: got %0d busyOk=%0b, required %0d", sel, lat, bok, expLat());
    end
    @(negedge clk);
    setInputs(32'h4, 32'h11111111, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setInputs('0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lastRead[0] = '0;
    lastRead[1] = '0;
    nVec++;
    if (curBusy() !== 1'b0 || curDout() !== 32'd0) begin
      nErr++;
      $display("[TB] FAIL abort_state dut%0d: busy=%0b dout=%08h, required 0 0", sel, curBusy(), curDout());
    end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (curReady()) pulses++;
      @(negedge clk);
    end
    nVec++;
    if (pulses !== 0) begin
      nErr++;
      $display("[TB] FAIL abort_pulses dut%0d: got %0d pulses, required 0", sel, pulses);
    end
    modelAccess(1'b0, 32'h4, '0, exp);
    doAccess(1'b1, 1'b0, 32'h4, '0, lat, rd, bok);
    nVec++;
    if (rd !== exp || lat !== expLat()) begin
      nErr++;
      $display("[TB] FAIL abort_readback dut%0d: data=%08h lat=%0d, required %08h lat=%0d", sel, rd, lat, exp, expLat());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_ignore_in_wait();
    test_both_strobes();
    test_random();
    test_reset_abort(0);
    test_reset_abort(1);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
